divisor_freq_prog: RTL



---
 rtl/divisor_freq_prog.sv | 98 +++++++++
 1 files changed

// File: rtl/divisor_freq_prog.sv
// Programmable multi-channel frequency divider: each channel counts enabled clocks up to a
// runtime-loadable period and emits a 1-cycle tick, a toggling square wave and its live count.
module divisor_freq_prog #(
  parameter int unsigned       WIDTH       = 18,
  parameter int unsigned       N_CH        = 4,
  parameter int unsigned       CH_W        = 2,
  parameter logic [WIDTH-1:0]  DEFAULT_DIV = WIDTH'(18'h3FFFF)
) (
  input  logic                  clock_in,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [CH_W-1:0]       load_ch,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  load_mode,
  output logic [N_CH-1:0]       tick_out,
  output logic [N_CH-1:0]       wave_out,
  output logic [N_CH-1:0]       done_out,
  output logic [N_CH*WIDTH-1:0] count_out
);

  typedef enum logic {StRun, StDone} state_e;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] last;
    logic             mode_q, mode_d;
    logic             tick_q, tick_d;
    logic             wave_q, wave_d;
    logic             sel;
    state_e           state_q, state_d;

    // Indices >= N_CH never match any channel, so such loads are dropped.
    assign sel  = load && (load_ch == CH_W'(i));
    // A period of 0 behaves as 1, so the wrap point is 0 for both.
    assign last = (period_q == '0) ? '0 : period_q - WIDTH'(1);

    always_comb begin
      count_d  = count_q;
      period_d = period_q;
      mode_d   = mode_q;
      wave_d   = wave_q;
      state_d  = state_q;
      tick_d   = 1'b0;
      if (sel) begin
        period_d = load_value;
        mode_d   = load_mode;
        count_d  = '0;
        wave_d   = 1'b0;
        state_d  = StRun;
      end else begin
        unique case (state_q)
          StRun: begin
            if (enable) begin
              if (count_q == last) begin
                count_d = '0;
                tick_d  = 1'b1;
                wave_d  = ~wave_q;
                if (mode_q) state_d = StDone;
              end else begin
                count_d = count_q + WIDTH'(1);
              end
            end
          end
          StDone: begin
          end
          default: begin
          end
        endcase
      end
    end

    always_ff @(posedge clock_in) begin
      if (reset) begin
        count_q  <= '0;
        period_q <= DEFAULT_DIV;
        mode_q   <= 1'b0;
        tick_q   <= 1'b0;
        wave_q   <= 1'b0;
        state_q  <= StRun;
      end else begin
        count_q  <= count_d;
        period_q <= period_d;
        mode_q   <= mode_d;
        tick_q   <= tick_d;
        wave_q   <= wave_d;
        state_q  <= state_d;
      end
    end

    assign tick_out[i]                = tick_q;
    assign wave_out[i]                = wave_q;
    assign done_out[i]                = (state_q == StDone);
    assign count_out[i*WIDTH +: WIDTH] = count_q;
  end

endmodule
